mux_2x1: RTL and testbench

- 2-to-1 selector used in the TinyCPU datapath.
- Provides a combinational output `outsmall` that selects between data inputs `muhsin` and `adithya` under control of `ss`.
- Also provides a clock-registered copy of the selection and a one-cycle pulse flagging select changes, for pipelined consumers.
- Zero-latency path is the primary function; registered outputs are auxiliary.

---
 rtl/mux_2x1_if.sv | 22 ++
 rtl/mux_2x1.sv | 38 +++
 tb/tb_mux_2x1.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mux_2x1_if.sv
// Signal bundle for the 2:1 selector: data/select inputs plus the
// combinational, registered and select-change outputs.
interface mux_2x1_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] muhsin;
    logic [WIDTH-1:0] adithya;
    logic             ss;
    logic [WIDTH-1:0] outsmall;
    logic [WIDTH-1:0] outsmall_q;
    logic             ss_changed;

    modport master (
        output muhsin, adithya, ss,
        input  outsmall, outsmall_q, ss_changed
    );

    modport slave (
        input  muhsin, adithya, ss,
        output outsmall, outsmall_q, ss_changed
    );
endinterface

// File: rtl/mux_2x1.sv
// TinyCPU 2:1 datapath selector: zero-latency mux output plus a registered
// copy and a one-cycle pulse whenever the captured select changes.
module mux_2x1 #(
    parameter int WIDTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_2x1_if.slave   bus
);
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] outsmall_q;
    logic             ss_q;
    logic             ss_q_prev;
    logic             ss_changed;

    // Ternary keeps bits where both inputs agree even if ss is X in sim.
    assign sel_data     = bus.ss ? bus.adithya : bus.muhsin;
    assign bus.outsmall = sel_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outsmall_q <= '0;
            ss_q       <= 1'b0;
            ss_q_prev  <= 1'b0;
            ss_changed <= 1'b0;
        end else begin
            outsmall_q <= sel_data;
            ss_q       <= bus.ss;
            ss_q_prev  <= ss_q;
            // Compares two already-registered selects, so the pulse lands one
            // cycle after capture and can never fire on the first edge out of reset.
            ss_changed <= (ss_q != ss_q_prev);
        end
    end

    assign bus.outsmall_q = outsmall_q;
    assign bus.ss_changed = ss_changed;
endmodule

// File: tb/tb_mux_2x1.sv
// Directed bench for mux_2x1: vector table on WIDTH=8 and WIDTH=1 instances,
// plus hand sequences for select-change pulses and asynchronous reset.
module tb_mux_2x1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mux_2x1_if #(.WIDTH(8)) b8 ();
    mux_2x1_if #(.WIDTH(1)) b1 ();

    mux_2x1 #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    mux_2x1 #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    typedef struct {
        logic [7:0] m;
        logic [7:0] a;
        logic       s;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] m, input logic [7:0] a, input logic s);
        b8.muhsin  = m;
        b8.adithya = a;
        b8.ss      = s;
        b1.muhsin  = m[0];
        b1.adithya = a[0];
        b1.ss      = s;
    endtask

    initial begin
        vecs[0] = '{m: 8'h01, a: 8'h01, s: 1'b0, exp: 8'h01};
        vecs[1] = '{m: 8'h00, a: 8'h01, s: 1'b0, exp: 8'h00};
        vecs[2] = '{m: 8'h00, a: 8'h00, s: 1'b1, exp: 8'h00};
        vecs[3] = '{m: 8'h01, a: 8'h00, s: 1'b1, exp: 8'h00};
        vecs[4] = '{m: 8'h01, a: 8'h01, s: 1'b1, exp: 8'h01};
        vecs[5] = '{m: 8'hA5, a: 8'h3C, s: 1'b0, exp: 8'hA5};
        vecs[6] = '{m: 8'hA5, a: 8'h3C, s: 1'b1, exp: 8'h3C};
        vecs[7] = '{m: 8'h5A, a: 8'hC3, s: 1'b0, exp: 8'h5A};

        // Reset: registered outputs cleared, combinational path live.
        drive(8'hA5, 8'h3C, 1'b1);
        #2;
        check("rst_q8", b8.outsmall_q, 8'h00);
        check("rst_q1", {7'b0, b1.outsmall_q}, 8'h00);
        check("rst_chg", {7'b0, b1.ss_changed}, 8'h00);
        check("rst_comb8", b8.outsmall, 8'h3C);
        drive(8'hA5, 8'h3C, 1'b0);
        #1;
        check("rst_comb8b", b8.outsmall, 8'hA5);
        check("rst_comb1b", {7'b0, b1.outsmall}, 8'h01);

        // Release with ss=1: first edge captures, no pulse until a cycle later.
        drive(8'h00, 8'h01, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_q1", {7'b0, b1.outsmall_q}, 8'h01);
        check("rel_chg0", {7'b0, b1.ss_changed}, 8'h00);
        @(posedge clk); #1;
        check("rel_chg1", {7'b0, b1.ss_changed}, 8'h01);
        @(posedge clk); #1;
        check("rel_chg2", {7'b0, b1.ss_changed}, 8'h00);

        // Table: combinational result immediately, registered after one edge.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].m, vecs[i].a, vecs[i].s);
            #1;
            check($sformatf("comb8[%0d]", i), b8.outsmall, vecs[i].exp);
            check($sformatf("comb1[%0d]", i), {7'b0, b1.outsmall}, {7'b0, vecs[i].exp[0]});
            @(posedge clk); #1;
            check($sformatf("reg8[%0d]", i), b8.outsmall_q, vecs[i].exp);
            check($sformatf("reg1[%0d]", i), {7'b0, b1.outsmall_q}, {7'b0, vecs[i].exp[0]});
        end

        // Steady ss=0 gives no pulse; a 0->1 toggle gives exactly one.
        @(negedge clk);
        drive(8'h00, 8'h01, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("steady_chg", {7'b0, b1.ss_changed}, 8'h00);
        check("steady_q1", {7'b0, b1.outsmall_q}, 8'h00);
        @(negedge clk);
        drive(8'h00, 8'h00, 1'b1);
        #1;
        check("tog_comb", {7'b0, b1.outsmall}, 8'h00);
        @(posedge clk); #1;
        check("tog_chg_cap", {7'b0, b1.ss_changed}, 8'h00);
        @(posedge clk); #1;
        check("tog_chg_hi", {7'b0, b1.ss_changed}, 8'h01);
        @(posedge clk); #1;
        check("tog_chg_lo", {7'b0, b1.ss_changed}, 8'h00);

        // Data flip with ss held: output changes with no clock edge.
        @(negedge clk);
        drive(8'h01, 8'h00, 1'b1);
        #1;
        check("flip_a0", {7'b0, b1.outsmall}, 8'h00);
        drive(8'h01, 8'h01, 1'b1);
        #1;
        check("flip_a1", {7'b0, b1.outsmall}, 8'h01);

        // Mid-stream async reset with outsmall_q=1 and a pending pulse.
        @(negedge clk);
        drive(8'h01, 8'h00, 1'b0);
        @(posedge clk); #1;
        check("pre_rst_q1", {7'b0, b1.outsmall_q}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_q1", {7'b0, b1.outsmall_q}, 8'h00);
        check("mid_rst_q8", b8.outsmall_q, 8'h00);
        check("mid_rst_chg", {7'b0, b1.ss_changed}, 8'h00);
        check("mid_rst_comb", {7'b0, b1.outsmall}, 8'h01);
        drive(8'hA5, 8'h3C, 1'b1);
        #1;
        check("mid_rst_comb8", b8.outsmall, 8'h3C);
        @(posedge clk); #1;
        check("mid_rst_hold8", b8.outsmall_q, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_q8", b8.outsmall_q, 8'h3C);
        check("post_rst_chg", {7'b0, b8.ss_changed}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
